sram_mem_ctrl: RTL and testbench

// - MEM-stage data-memory controller: turns single-cycle rd_en/wr_en requests into multi-cycle 16-bit SRAM accesses.
// - Produces the 32-bit read data that the MEM stage forwards as mem_result.
// - Produces ready; the pipeline uses freeze = ~ready to hold every stage register, including the MEM/WB register.
// - Each 32-bit word is accessed as two halfwords, low half first.

---
 rtl/sram_mem_ctrl_if.sv | 25 ++
 rtl/sram_mem_ctrl.sv | 106 ++++++++++
 tb/tb_sram_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_ctrl_if.sv
// Bundles the MEM-stage request/response signals and the 16-bit SRAM pins
// for sram_mem_ctrl.
interface sram_mem_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// WAIT_CYCLES-long halfword SRAM phases (low half first) and stalls via ready.
module sram_mem_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    sram_mem_ctrl_if.slave bus
);
    localparam int unsigned CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST     = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_wr;
    logic [16:0]   widx_q;
    logic [31:0]   wdata_q;
    logic [16:0]   widx_in;
    logic          req;

    always_comb begin
        req     = bus.rd_en | bus.wr_en;
        widx_in = 17'((bus.address - BASE_ADDR) >> 2);
    end

    always_comb begin
        bus.ready = 1'b0;
        case (state)
            IDLE:    bus.ready = ~req;
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // SRAM pins are registered one cycle ahead, so each phase's address,
    // data and strobe are already valid in the first cycle of that phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_wr           <= 1'b0;
            widx_q          <= '0;
            wdata_q         <= '0;
            bus.read_data   <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr           <= bus.wr_en;
                        widx_q          <= widx_in;
                        wdata_q         <= bus.write_data;
                        cnt             <= '0;
                        state           <= LOW;
                        bus.sram_addr   <= {widx_in, 1'b0};
                        bus.sram_dq_out <= bus.write_data[15:0];
                        bus.sram_dq_oe  <= bus.wr_en;
                        bus.sram_we_n   <= ~bus.wr_en;
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        if (!op_wr) begin
                            bus.read_data[15:0] <= bus.sram_dq_in;
                        end
                        cnt             <= '0;
                        state           <= HIGH;
                        bus.sram_addr   <= {widx_q, 1'b1};
                        bus.sram_dq_out <= wdata_q[31:16];
                        bus.sram_we_n   <= ~op_wr;
                    end else begin
                        cnt           <= cnt + CW'(1);
                        bus.sram_we_n <= ~op_wr | (cnt == PRE_LAST);
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        if (!op_wr) begin
                            bus.read_data[31:16] <= bus.sram_dq_in;
                        end
                        cnt            <= '0;
                        state          <= DONE;
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_we_n  <= 1'b1;
                    end else begin
                        cnt           <= cnt + CW'(1);
                        bus.sram_we_n <= ~op_wr | (cnt == PRE_LAST);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: behavioural 16-bit SRAM plus a
// word-level reference memory, directed scenarios and randomized accesses.
module tb_sram_mem_ctrl;
    localparam int W = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sram_mem_ctrl_if bus ();

    sram_mem_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: unwritten locations read a fixed address-derived pattern.
    logic [15:0] mem     [0:262143];
    bit          wr_mark [0:262143];
    logic        poke_en;
    logic [17:0] poke_addr;
    logic [15:0] poke_data;

    function automatic logic [15:0] init_half(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    assign bus.sram_dq_in = wr_mark[bus.sram_addr] ? mem[bus.sram_addr] : init_half(bus.sram_addr);

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr]     <= poke_data;
            wr_mark[poke_addr] <= 1'b1;
        end else if (!bus.sram_we_n && bus.sram_dq_oe) begin
            mem[bus.sram_addr]     <= bus.sram_dq_out;
            wr_mark[bus.sram_addr] <= 1'b1;
        end
    end

    // Word-level reference: word index -> 32-bit value.
    logic [31:0] model [int unsigned];
    logic [31:0] exp_rd;

    function automatic logic [16:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    function automatic logic [31:0] model_rd(input logic [16:0] w);
        if (model.exists(int'(w))) return model[int'(w)];
        return {init_half({w, 1'b1}), init_half({w, 1'b0})};
    endfunction

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ready !== 1'b1) begin
                failures++; $display("FAIL idle_ready: got %b expected 1", bus.ready);
            end
            checks++;
            if (bus.sram_we_n !== 1'b1) begin
                failures++; $display("FAIL idle_we_n: got %b expected 1", bus.sram_we_n);
            end
            checks++;
            if (bus.read_data !== exp_rd) begin
                failures++; $display("FAIL idle_read_data: got %h expected %h", bus.read_data, exp_rd);
            end
            @(posedge clk); #1;
        end
    endtask

    // Starts at #1 after the edge opening c0; returns #1 into the IDLE cycle after DONE.
    task automatic do_access(input bit is_wr, input bit both, input logic [31:0] addr,
                             input logic [31:0] data, input int hold);
        logic [16:0] w;
        logic        hi;
        int          k;
        logic [17:0] e_addr;
        logic        e_we;
        logic [15:0] e_dq;
        w = word_idx(addr);
        bus.rd_en = !is_wr || both;
        bus.wr_en = is_wr;
        bus.address = addr;
        bus.write_data = data;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++; $display("FAIL c0_ready: got %b expected 0", bus.ready);
        end
        for (int c = 1; c <= 2*W+1; c++) begin
            @(posedge clk); #1;
            if (c >= hold) begin
                bus.rd_en = 1'b0; bus.wr_en = 1'b0;
                bus.address = $urandom; bus.write_data = $urandom;
            end
            @(negedge clk);
            if (c <= 2*W) begin
                hi     = (c > W);
                k      = (c - 1) % W;
                e_addr = {w, hi};
                e_we   = is_wr ? (k == W-1) : 1'b1;
                e_dq   = hi ? data[31:16] : data[15:0];
                checks++;
                if (bus.ready !== 1'b0) begin
                    failures++; $display("FAIL c%0d_ready: got %b expected 0", c, bus.ready);
                end
                checks++;
                if (bus.sram_addr !== e_addr) begin
                    failures++; $display("FAIL c%0d_sram_addr: got %h expected %h", c, bus.sram_addr, e_addr);
                end
                checks++;
                if (bus.sram_we_n !== e_we) begin
                    failures++; $display("FAIL c%0d_we_n: got %b expected %b", c, bus.sram_we_n, e_we);
                end
                checks++;
                if (bus.sram_dq_oe !== is_wr) begin
                    failures++; $display("FAIL c%0d_dq_oe: got %b expected %b", c, bus.sram_dq_oe, is_wr);
                end
                if (is_wr) begin
                    checks++;
                    if (bus.sram_dq_out !== e_dq) begin
                        failures++; $display("FAIL c%0d_dq_out: got %h expected %h", c, bus.sram_dq_out, e_dq);
                    end
                end
            end else begin
                if (!is_wr) exp_rd = model_rd(w);
                checks++;
                if (bus.ready !== 1'b1) begin
                    failures++; $display("FAIL done_ready: got %b expected 1", bus.ready);
                end
                checks++;
                if (bus.read_data !== exp_rd) begin
                    failures++; $display("FAIL done_read_data: got %h expected %h", bus.read_data, exp_rd);
                end
            end
        end
        if (is_wr) model[int'(w)] = data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        checks++;
        if (bus.sram_dq_oe !== 1'b0) begin
            failures++; $display("FAIL reset_dq_oe: got %b expected 0", bus.sram_dq_oe);
        end
        checks++;
        if (bus.sram_addr !== 18'd0) begin
            failures++; $display("FAIL reset_sram_addr: got %h expected 0", bus.sram_addr);
        end
        checks++;
        if (bus.sram_dq_out !== 16'd0) begin
            failures++; $display("FAIL reset_dq_out: got %h expected 0", bus.sram_dq_out);
        end
        @(posedge clk); #1;
        idle_cycles(3);
    endtask

    task automatic test_write;
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1);
        idle_cycles(1);
    endtask

    task automatic test_read;
        poke(18'd10, 16'h1234);
        poke(18'd11, 16'hABCD);
        model[5] = 32'hABCD1234;
        do_access(1'b0, 1'b0, 32'd1044, 32'h0, 1);
        checks++;
        if (exp_rd !== 32'hABCD1234 || bus.read_data !== 32'hABCD1234) begin
            failures++; $display("FAIL read_1044: got %h expected ABCD1234", bus.read_data);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 1'b0, 32'd1184, 32'hDEADBEEF, 1);
        do_access(1'b0, 1'b0, 32'd1184, 32'h0, 1);
        checks++;
        if (bus.read_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL b2b_read: got %h expected DEADBEEF", bus.read_data);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_access;
        logic [16:0] w;
        w = word_idx(32'd1300);
        bus.wr_en = 1'b1; bus.rd_en = 1'b0;
        bus.address = 32'd1300; bus.write_data = 32'hCAFEF00D;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = '0;
        // Low half and first high-half strobe landed before the abort.
        model[int'(w)] = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (bus.sram_dq_oe !== 1'b0) begin
            failures++; $display("FAIL rst_mid_dq_oe: got %b expected 0", bus.sram_dq_oe);
        end
        @(posedge clk); #1;
        idle_cycles(2);
        do_access(1'b0, 1'b0, 32'd1044, 32'h0, 1);
        idle_cycles(1);
    endtask

    task automatic test_drop_and_both;
        do_access(1'b0, 1'b0, 32'd1028, 32'h0, 2);
        idle_cycles(1);
        do_access(1'b1, 1'b1, 32'd1028, 32'h5A5AA5A5, 1);
        do_access(1'b0, 1'b0, 32'd1031, 32'h0, 1);
        idle_cycles(1);
    endtask

    task automatic test_wrap;
        do_access(1'b1, 1'b0, 32'd0, 32'h01234567, 3);
        do_access(1'b0, 1'b0, 32'd2, 32'h0, 1);
        idle_cycles(1);
    endtask

    task automatic test_random;
        bit          wr;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_access(wr, wr & 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 2*W+1));
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
        exp_rd = '0;
        #1;
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_reset_mid_access;
        test_drop_and_both;
        test_wrap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
